// File: rtl/block_ram_arbiter.sv
// Round-robin arbiter sharing one BlockRam port (16-bit, byte enables, 1-cycle read) among NUM_MASTERS.
// Optional start-up memory clear is enabled by defining ARB_CLEAR_EN.
module block_ram_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int WORDS = 16,
  localparam int ADDR_BITS = $clog2(WORDS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_MASTERS-1:0]         m_access,
  input  logic [NUM_MASTERS*ADDR_BITS-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]         m_wr_en,
  input  logic [NUM_MASTERS*2-1:0]       m_bytesel,
  input  logic [NUM_MASTERS*16-1:0]      m_wr_data,
  output logic [NUM_MASTERS-1:0]         m_ack,
  output logic [15:0]                    m_data,
  output logic [ADDR_BITS-1:0]           ram_addr,
  output logic                           ram_wr_en,
  output logic [1:0]                     ram_be,
  output logic [15:0]                    ram_wdata,
  input  logic [15:0]                    ram_q,
  output logic                           busy
);

  localparam int PTR_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, CLEAR} state_t;

`ifdef ARB_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state, state_next;
  logic [PTR_W-1:0] grant, rr_ptr, pick, idx;
  logic             pick_vld;

  logic [ADDR_BITS-1:0] req_addr;
  logic                 req_wr;
  logic [1:0]           req_be;
  logic [15:0]          req_wdata;

  logic [ADDR_BITS-1:0] addr_arr  [NUM_MASTERS];
  logic [1:0]           be_arr    [NUM_MASTERS];
  logic [15:0]          wdata_arr [NUM_MASTERS];

`ifdef ARB_CLEAR_EN
  logic [ADDR_BITS-1:0] clr_cnt;
`endif

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_MASTERS-1)) return '0;
    return p + PTR_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr[g*ADDR_BITS +: ADDR_BITS];
    assign be_arr[g]    = m_bytesel[g*2 +: 2];
    assign wdata_arr[g] = m_wr_data[g*16 +: 16];
  end

  // Scan downwards so the requester closest to rr_ptr is the one left in pick.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = NUM_MASTERS-1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (m_access[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_vld) state_next = ISSUE;
      ISSUE:   state_next = ACK;
      ACK:     state_next = IDLE;
`ifdef ARB_CLEAR_EN
      CLEAR:   if (clr_cnt == ADDR_BITS'(WORDS-1)) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RST_STATE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_vld) begin
        grant  <= pick;
        rr_ptr <= next_ptr(pick);
      end
    end
  end

`ifdef ARB_CLEAR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_BITS'(1);
  end
`endif

  // Request register: the granted master's inputs are frozen here at the grant edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && pick_vld) begin
      req_addr  <= addr_arr[pick];
      req_wr    <= m_wr_en[pick];
      req_be    <= be_arr[pick];
      req_wdata <= wdata_arr[pick];
    end
  end

  // Outputs are registered: what a state decides appears on the pins the following cycle,
  // so the RAM samples during ACK and its registered q lines up with m_ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_wr_en <= 1'b0;
      ram_be    <= 2'b00;
      ram_wdata <= 16'h0000;
      m_ack     <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      ram_be    <= 2'b00;
      m_ack     <= '0;
      case (state)
        ISSUE: begin
          ram_addr  <= req_addr;
          ram_wdata <= req_wdata;
          ram_wr_en <= req_wr;
          ram_be    <= req_wr ? req_be : 2'b11;
        end
        ACK: m_ack <= NUM_MASTERS'(1) << grant;
`ifdef ARB_CLEAR_EN
        CLEAR: begin
          ram_addr  <= clr_cnt;
          ram_wdata <= 16'h0000;
          ram_wr_en <= 1'b1;
          ram_be    <= 2'b11;
        end
`endif
        default: ;
      endcase
    end
  end

  assign m_data = (|m_ack) ? ram_q : 16'h0000;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Directed bench for block_ram_arbiter: vector table of single accesses plus
// round-robin, starvation, mid-operation reset and (with ARB_CLEAR_EN) clear sequences.
module tb_block_ram_arbiter;
  localparam int NM = 3;
  localparam int WORDS = 16;
  localparam int AB = 4;
`ifdef ARB_CLEAR_EN
  localparam logic        BUSY_RST = 1'b1;
  localparam logic [15:0] EXP_A2   = 16'h0000;
  localparam logic [15:0] EXP_A7   = 16'h0000;
`else
  localparam logic        BUSY_RST = 1'b0;
  localparam logic [15:0] EXP_A2   = 16'hABCD;
  localparam logic [15:0] EXP_A7   = 16'h0777;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NM-1:0]    m_access, m_wr_en, m_ack;
  logic [NM*AB-1:0] m_addr;
  logic [NM*2-1:0]  m_bytesel;
  logic [NM*16-1:0] m_wr_data;
  logic [15:0]      m_data, ram_wdata, ram_q;
  logic [AB-1:0]    ram_addr;
  logic             ram_wr_en;
  logic [1:0]       ram_be;
  logic             busy;
  int checks = 0;
  int errors = 0;
  logic [15:0] mem [WORDS];

  typedef struct {
    int          m;
    bit          wr;
    logic [3:0]  a;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] rd;
  } vec_t;
  vec_t vecs [15];

  block_ram_arbiter #(.NUM_MASTERS(NM), .WORDS(WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .m_access(m_access), .m_addr(m_addr),
    .m_wr_en(m_wr_en), .m_bytesel(m_bytesel), .m_wr_data(m_wr_data),
    .m_ack(m_ack), .m_data(m_data), .ram_addr(ram_addr), .ram_wr_en(ram_wr_en),
    .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // BlockRam port A model: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (ram_wr_en) begin
      if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
    end
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input bit wr, input logic [3:0] a,
                         input logic [1:0] be, input logic [15:0] d);
    m_addr[m*AB +: AB]      = a;
    m_wr_en[m]              = wr;
    m_bytesel[m*2 +: 2]     = be;
    m_wr_data[m*16 +: 16]   = d;
    m_access[m]             = 1'b1;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
`ifdef ARB_CLEAR_EN
    begin
      int n;
      bit acked;
      n = 0;
      acked = 1'b0;
      while (busy && n < 40) begin
        tick();
        n++;
        if (m_ack != '0) acked = 1'b1;
      end
      chk("clear_busy_cycles", 32'(n), 32'(WORDS));
      chk("clear_no_ack", 32'(acked), 32'(0));
    end
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    release_reset();
  endtask

  task automatic wait_ack(input logic [NM-1:0] mask, input bit chkd,
                          input logic [15:0] d, input string name);
    int n;
    n = 0;
    while (m_ack == '0 && n < 12) begin
      tick();
      n++;
    end
    chk({name, "_ack"}, 32'(m_ack), 32'(mask));
    if (chkd) chk({name, "_data"}, 32'(m_data), 32'(d));
  endtask

  task automatic run_vec(input vec_t v, input int i);
    string s;
    s = $sformatf("v%0d", i);
    set_req(v.m, v.wr, v.a, v.be, v.wd);
    tick();
    chk({s, "_ack_e0"}, 32'(m_ack), 32'(0));
    chk({s, "_busy"}, 32'(busy), 32'(1));
    tick();
    chk({s, "_ack_e1"}, 32'(m_ack), 32'(0));
    chk({s, "_data_idle"}, 32'(m_data), 32'(0));
    chk({s, "_ram_addr"}, 32'(ram_addr), 32'(v.a));
    chk({s, "_ram_wr_en"}, 32'(ram_wr_en), 32'(v.wr));
    chk({s, "_ram_be"}, 32'(ram_be), v.wr ? 32'(v.be) : 32'(2'b11));
    if (v.wr) chk({s, "_ram_wdata"}, 32'(ram_wdata), 32'(v.wd));
    tick();
    chk({s, "_ack"}, 32'(m_ack), 32'(3'b001 << v.m));
    if (!v.wr) chk({s, "_rdata"}, 32'(m_data), 32'(v.rd));
    chk({s, "_wr_en_ack"}, 32'(ram_wr_en), 32'(0));
    chk({s, "_be_ack"}, 32'(ram_be), 32'(0));
    m_access[v.m] = 1'b0;
    tick();
    chk({s, "_ack_after"}, 32'(m_ack), 32'(0));
    chk({s, "_busy_after"}, 32'(busy), 32'(0));
  endtask

  function automatic int ack_index(input logic [NM-1:0] a);
    for (int k = 0; k < NM; k++) if (a[k]) return k;
    return -1;
  endfunction

  initial begin
    int n, cyc, idx, acks_late;
    int          got_m [12];
    int          got_c [12];
    logic [15:0] got_d [12];
    int          rr_m  [4];
    logic [15:0] rr_d  [4];
    vec_t        v;

    vecs[0]  = '{0, 1'b1, 4'd2, 2'b11, 16'hABCD, 16'h0000};
    vecs[1]  = '{1, 1'b0, 4'd2, 2'b11, 16'h0000, 16'hABCD};
    vecs[2]  = '{2, 1'b1, 4'd4, 2'b11, 16'hFFFF, 16'h0000};
    vecs[3]  = '{2, 1'b1, 4'd4, 2'b01, 16'h0012, 16'h0000};
    vecs[4]  = '{2, 1'b0, 4'd4, 2'b11, 16'h0000, 16'hFF12};
    vecs[5]  = '{2, 1'b1, 4'd4, 2'b10, 16'h3400, 16'h0000};
    vecs[6]  = '{2, 1'b0, 4'd4, 2'b11, 16'h0000, 16'h3412};
    vecs[7]  = '{0, 1'b1, 4'd9, 2'b11, 16'h1111, 16'h0000};
    vecs[8]  = '{1, 1'b1, 4'd9, 2'b00, 16'hBEEF, 16'h0000};
    vecs[9]  = '{2, 1'b0, 4'd9, 2'b11, 16'h0000, 16'h1111};
    vecs[10] = '{0, 1'b1, 4'd5, 2'b11, 16'h0555, 16'h0000};
    vecs[11] = '{1, 1'b1, 4'd6, 2'b11, 16'h0666, 16'h0000};
    vecs[12] = '{2, 1'b1, 4'd7, 2'b11, 16'h0777, 16'h0000};
    vecs[13] = '{1, 1'b0, 4'd7, 2'b00, 16'h0000, 16'h0777};
    vecs[14] = '{2, 1'b0, 4'd6, 2'b11, 16'h0000, 16'h0666};
    rr_m = '{0, 1, 2, 0};
    rr_d = '{16'h0555, 16'h0666, 16'h0777, 16'h0555};

    reset_n = 1'b0;
    m_access = '0; m_wr_en = '0; m_addr = '0; m_bytesel = '0; m_wr_data = '0;
    tick();
    tick();
    chk("rst_ack", 32'(m_ack), 32'(0));
    chk("rst_wr_en", 32'(ram_wr_en), 32'(0));
    chk("rst_be", 32'(ram_be), 32'(0));
    chk("rst_addr", 32'(ram_addr), 32'(0));
    chk("rst_wdata", 32'(ram_wdata), 32'(0));
    chk("rst_data", 32'(m_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(BUSY_RST));
    release_reset();

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Round robin: all three request; master 0 keeps requesting after its first ack.
    set_req(0, 1'b0, 4'd5, 2'b11, 16'h0);
    set_req(1, 1'b0, 4'd6, 2'b11, 16'h0);
    set_req(2, 1'b0, 4'd7, 2'b11, 16'h0);
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (m_ack != '0) begin
        chk("rr_onehot", 32'($onehot(m_ack)), 32'(1));
        idx = ack_index(m_ack);
        got_m[n] = idx; got_d[n] = m_data; got_c[n] = cyc;
        if (n != 0 && idx >= 0) m_access[idx] = 1'b0;
        n++;
      end
    end
    m_access = '0;
    chk("rr_ack_count", 32'(n), 32'(4));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr%0d_master", i), 32'(got_m[i]), 32'(rr_m[i]));
      chk($sformatf("rr%0d_data", i), 32'(got_d[i]), 32'(rr_d[i]));
      if (i == 0) chk("rr0_latency", 32'(got_c[0]), 32'(3));
      else chk($sformatf("rr%0d_spacing", i), 32'(got_c[i] - got_c[i-1]), 32'(3));
    end
    tick();

    // Starvation: masters 0 and 1 request continuously; rr_ptr is 1 after the last grant to 0.
    set_req(0, 1'b0, 4'd5, 2'b11, 16'h0);
    set_req(1, 1'b0, 4'd6, 2'b11, 16'h0);
    n = 0; cyc = 0;
    while (n < 12 && cyc < 60) begin
      tick();
      cyc++;
      if (m_ack != '0) begin
        got_m[n] = ack_index(m_ack); got_d[n] = m_data;
        n++;
        if (n == 12) m_access = '0;
      end
    end
    m_access = '0;
    chk("starve_count", 32'(n), 32'(12));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("starve%0d_master", i), 32'(got_m[i]), 32'((i % 2 == 0) ? 1 : 0));
      chk($sformatf("starve%0d_data", i), 32'(got_d[i]),
          32'((i % 2 == 0) ? 16'h0666 : 16'h0555));
    end
    acks_late = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_ack != '0) acks_late++;
    end
    chk("starve_no_extra_ack", 32'(acks_late), 32'(0));

    // Reset during ISSUE of a master 1 write; afterwards master 0 must win over 1 and 2.
    set_req(1, 1'b1, 4'd3, 2'b11, 16'h5A5A);
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(m_ack), 32'(0));
    chk("midrst_wr_en", 32'(ram_wr_en), 32'(0));
    chk("midrst_be", 32'(ram_be), 32'(0));
    chk("midrst_addr", 32'(ram_addr), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(BUSY_RST));
    tick();
    chk("midrst_ack_hold", 32'(m_ack), 32'(0));
    set_req(0, 1'b0, 4'd2, 2'b11, 16'h0);
    set_req(2, 1'b0, 4'd7, 2'b11, 16'h0);
    tick();
    release_reset();
    wait_ack(3'b001, 1'b1, EXP_A2, "postrst_m0");
    m_access[0] = 1'b0;
    tick();
    wait_ack(3'b010, 1'b0, 16'h0, "postrst_m1");
    m_access[1] = 1'b0;
    tick();
    wait_ack(3'b100, 1'b1, EXP_A7, "postrst_m2");
    m_access[2] = 1'b0;
    tick();
    v = '{2, 1'b0, 4'd3, 2'b11, 16'h0000, 16'h5A5A};
    run_vec(v, 100);

`ifdef ARB_CLEAR_EN
    for (int i = 0; i < WORDS; i++) begin
      v = '{0, 1'b1, 4'(i), 2'b11, 16'hDEAD ^ 16'(i), 16'h0000};
      run_vec(v, 200 + i);
    end
    set_req(0, 1'b0, 4'd7, 2'b11, 16'h0);
    do_reset();
    wait_ack(3'b001, 1'b1, 16'h0000, "clear_read");
    m_access = '0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_ram_arbiter.md
Name: block_ram_arbiter

Overview:
Round-robin arbiter sharing one BlockRam port (16-bit data, 2-bit byte enable, 1-cycle registered read) between NUM_MASTERS requesters. Each master uses an access/ack handshake. The arbiter sequences one RAM access at a time and returns the read data with the ack. It sits between CPU-side/DMA-side bus masters and port A of a BlockRam instance; port B stays free for other logic.

Parameters:
NUM_MASTERS, 3, number of requesters (2..8)
WORDS, 16, BlockRam depth; ADDR_BITS = $clog2(WORDS)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
m_access  in  NUM_MASTERS  per-master request; held stable until that master's ack
m_addr  in  NUM_MASTERS*ADDR_BITS  packed word addresses, master i at [i*ADDR_BITS +: ADDR_BITS]
m_wr_en  in  NUM_MASTERS  per-master write (1) / read (0)
m_bytesel  in  NUM_MASTERS*2  packed byte enables, bit0 = low byte
m_wr_data  in  NUM_MASTERS*16  packed write data
m_ack  out  NUM_MASTERS  one-hot, one-cycle completion pulse
m_data  out  16  read data, valid only while any m_ack bit is 1, else 16'h0000
ram_addr  out  ADDR_BITS  to BlockRam addr
ram_wr_en  out  1  to BlockRam wr_en
ram_be  out  2  to BlockRam be
ram_wdata  out  16  to BlockRam wdata
ram_q  in  16  from BlockRam q
busy  out  1  arbiter not in IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE (CLEAR if ARB_CLEAR_EN); grant=0; rr_ptr=0 (master 0 highest priority); m_ack=0; ram_wr_en=0; ram_be=2'b00; ram_addr=0; ram_wdata=0; m_data=0; busy=0 (1 under ARB_CLEAR_EN).
- States: IDLE -> ISSUE -> ACK -> IDLE.
- IDLE: if any m_access is 1 at a clock edge, latch grant = first requesting master at or after rr_ptr, wrapping modulo NUM_MASTERS. Latch its addr, wr_en, bytesel and wr_data into the request register. Set rr_ptr = grant+1 (wrap NUM_MASTERS-1 -> 0). Go to ISSUE. With no request, stay in IDLE.
- ISSUE (1 cycle): drive ram_addr/ram_wdata from the request register. ram_wr_en = latched wr_en. ram_be = latched bytesel for writes, 2'b11 for reads. Go to ACK.
- ACK (1 cycle): m_ack[grant]=1 and m_data=ram_q, for reads and writes. ram_wr_en=0, ram_be=2'b00. Go to IDLE.
- Latency: access sampled at edge E0; ack high from E2 to E3. Maximum throughput is one access per 3 cycles.
- A master still asserting m_access in the cycle after its ack is treated as a new request and arbitrated normally. Round-robin then favours other waiting masters.
- A request with bytesel=2'b00 and wr_en=1 still completes and acks; the RAM write is a no-op.
- Changes to the inputs of an ungranted master while waiting are allowed. The granted master's inputs are ignored after the grant edge because they are latched.
- Outside ISSUE/CLEAR: ram_wr_en=0 and ram_be=2'b00; ram_addr holds its last value.
- Reset asserted mid-ISSUE or mid-ACK: immediate return to reset values. No ack is issued; the in-flight write may or may not have committed.

Optional Feature:
ARB_CLEAR_EN. Defined: after reset release the FSM starts in CLEAR and writes 16'h0000 with ram_be=2'b11 to addresses 0..WORDS-1, one per cycle (WORDS cycles). busy=1 throughout CLEAR. m_access is ignored (not acked) until CLEAR finishes. The next state is IDLE, where pending requests are arbitrated. Not defined: no CLEAR state, FSM resets to IDLE, and busy reflects only ISSUE/ACK.

Test Plan:
- Single read: preload addr 2 = 16'hABCD via master 0 write. Master 1 reads addr 2 -> m_ack[1] pulses exactly 2 edges after the access edge, m_data=16'hABCD, no other ack bit set.
- Byte-enable write: master 2 writes 16'hFFFF to addr 4, then 16'h0012 with bytesel=01, then reads -> 16'hFF12. Write 16'h3400 with bytesel=10, then read -> 16'h3412.
- Round-robin: all three masters hold access (reads of addrs 5,6,7) and each drops after its ack -> acks in order 0,1,2, with 3-cycle spacing. Master 0 re-requesting immediately after its ack is served after 1 and 2.
- Starvation check: masters 0 and 1 request continuously for 12 grants -> grants alternate 0,1,0,1…
- Reset mid-operation: pull reset_n low during ISSUE of a master 1 write -> m_ack stays 0, ram_wr_en=0 immediately. After release, a master 0 request is granted first (rr_ptr=0).
- ARB_CLEAR_EN build: write junk to all words, pulse reset, hold master 0 access from release -> busy=1 for 16 cycles, no ack during CLEAR, then a read of any address returns 16'h0000.
